// File: rtl/freq_period_capture.sv
// Per-channel frequency/period front end: synchronises fin_i, counts clk_i cycles
// across a programmed number of fin_i periods and hands each result over with valid/ack.
module freq_period_capture #(
    parameter int CNT_WIDTH    = 30,
    parameter int PERIOD_WIDTH = 24,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    fin_i,
    input  logic [PERIOD_WIDTH-1:0] target_i,
    output logic [CNT_WIDTH-1:0]    result_clk_o,
    output logic [PERIOD_WIDTH-1:0] result_periods_o,
    output logic                    result_valid_o,
    input  logic                    result_ack_i,
    output logic                    timeout_o,
    output logic                    overrun_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_prev;
    state_t                  r_state;
    logic [CNT_WIDTH-1:0]    r_clk_cnt;
    logic [PERIOD_WIDTH-1:0] r_per_cnt;
    logic [PERIOD_WIDTH-1:0] r_tgt;
    logic [CNT_WIDTH-1:0]    r_result_clk;
    logic [PERIOD_WIDTH-1:0] r_result_periods;
    logic                    r_valid;
    logic                    r_timeout;
    logic                    r_overrun;

    logic                    w_rise;
    logic [PERIOD_WIDTH-1:0] w_tgt_in;
    logic [PERIOD_WIDTH-1:0] w_per_inc;
    logic                    w_clk_sat;
    logic                    w_terminal;
    logic                    w_ack;
    logic                    w_capture;
    logic [CNT_WIDTH-1:0]    w_cap_clk;
    logic [PERIOD_WIDTH-1:0] w_cap_periods;
    logic                    w_cap_timeout;
    state_t                  w_state_next;
    logic [CNT_WIDTH-1:0]    w_clk_cnt_next;
    logic [PERIOD_WIDTH-1:0] w_per_cnt_next;
    logic [PERIOD_WIDTH-1:0] w_tgt_next;
    logic [CNT_WIDTH-1:0]    w_result_clk_next;
    logic [PERIOD_WIDTH-1:0] w_result_periods_next;
    logic                    w_valid_next;
    logic                    w_timeout_next;
    logic                    w_overrun_next;

    assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_tgt_in   = (target_i == '0) ? PERIOD_WIDTH'(1) : target_i;
    assign w_per_inc  = r_per_cnt + PERIOD_WIDTH'(1);
    assign w_clk_sat  = &r_clk_cnt;
    assign w_terminal = (r_state == ST_COUNT) && w_rise && (w_per_inc == r_tgt);
    assign w_ack      = result_ack_i && r_valid;

    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt;
        w_per_cnt_next = r_per_cnt;
        w_tgt_next     = r_tgt;
        w_capture      = 1'b0;
        w_cap_clk      = '0;
        w_cap_periods  = '0;
        w_cap_timeout  = 1'b0;

        if (!enable_i) begin
            w_state_next   = ST_IDLE;
            w_clk_cnt_next = '0;
            w_per_cnt_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_ARM;
                end
                ST_ARM: begin
                    if (w_rise) begin
                        w_state_next   = ST_COUNT;
                        w_clk_cnt_next = '0;
                        w_per_cnt_next = '0;
                        w_tgt_next     = w_tgt_in;
                    end
                end
                ST_COUNT: begin
                    if (w_terminal) begin
                        // Terminal edge doubles as the next window's start edge.
                        w_capture      = 1'b1;
                        w_cap_clk      = w_clk_sat ? '1 : r_clk_cnt + CNT_WIDTH'(1);
                        w_cap_periods  = r_tgt;
                        w_clk_cnt_next = '0;
                        w_per_cnt_next = '0;
                        w_tgt_next     = w_tgt_in;
                    end else if (w_clk_sat) begin
                        w_capture      = 1'b1;
                        w_cap_clk      = '1;
                        w_cap_periods  = r_per_cnt;
                        w_cap_timeout  = 1'b1;
                        w_state_next   = ST_ARM;
                        w_clk_cnt_next = '0;
                        w_per_cnt_next = '0;
                    end else begin
                        w_clk_cnt_next = r_clk_cnt + CNT_WIDTH'(1);
                        if (w_rise) begin
                            w_per_cnt_next = w_per_inc;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Ack and capture are independent; a capture wins valid, a coincident ack suppresses overrun.
    always_comb begin
        w_result_clk_next     = r_result_clk;
        w_result_periods_next = r_result_periods;
        w_timeout_next        = r_timeout;
        w_valid_next          = r_valid;
        w_overrun_next        = r_overrun;

        if (w_ack) begin
            w_valid_next   = 1'b0;
            w_overrun_next = 1'b0;
        end
        if (w_capture) begin
            w_result_clk_next     = w_cap_clk;
            w_result_periods_next = w_cap_periods;
            w_timeout_next        = w_cap_timeout;
            w_valid_next          = 1'b1;
            if (r_valid && !result_ack_i) begin
                w_overrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sync           <= '0;
            r_prev           <= 1'b0;
            r_state          <= ST_IDLE;
            r_clk_cnt        <= '0;
            r_per_cnt        <= '0;
            r_tgt            <= '0;
            r_result_clk     <= '0;
            r_result_periods <= '0;
            r_valid          <= 1'b0;
            r_timeout        <= 1'b0;
            r_overrun        <= 1'b0;
        end else begin
            r_sync           <= {r_sync[SYNC_STAGES-2:0], fin_i};
            r_prev           <= r_sync[SYNC_STAGES-1];
            r_state          <= w_state_next;
            r_clk_cnt        <= w_clk_cnt_next;
            r_per_cnt        <= w_per_cnt_next;
            r_tgt            <= w_tgt_next;
            r_result_clk     <= w_result_clk_next;
            r_result_periods <= w_result_periods_next;
            r_valid          <= w_valid_next;
            r_timeout        <= w_timeout_next;
            r_overrun        <= w_overrun_next;
        end
    end

    assign result_clk_o     = r_result_clk;
    assign result_periods_o = r_result_periods;
    assign result_valid_o   = r_valid;
    assign timeout_o        = r_timeout;
    assign overrun_o        = r_overrun;
    assign busy_o           = (r_state == ST_ARM) || (r_state == ST_COUNT);

endmodule

// File: tb/tb_freq_period_capture.sv
// Directed and randomized checks of freq_period_capture; expected results come from
// plain arithmetic on the generated fin_i waveform (period * target, saturation value).
module tb_freq_period_capture;

    localparam int CW  = 8;
    localparam int PW  = 8;
    localparam int SS  = 2;
    localparam int SAT = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          enable_i;
    logic          fin_i;
    logic [PW-1:0] target_i;
    logic [CW-1:0] result_clk_o;
    logic [PW-1:0] result_periods_o;
    logic          result_valid_o;
    logic          result_ack_i;
    logic          timeout_o;
    logic          overrun_o;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;

    // fin_i source: free-running square wave of gen_period cycles, or gen_level when gen_period is 0.
    int   gen_period = 0;
    int   gen_phase  = 0;
    logic gen_level  = 1'b0;
    logic gen_wave   = 1'b0;
    assign fin_i = (gen_period == 0) ? gen_level : gen_wave;

    always #5 clk_i = ~clk_i;

    freq_period_capture #(
        .CNT_WIDTH   (CW),
        .PERIOD_WIDTH(PW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .enable_i        (enable_i),
        .fin_i           (fin_i),
        .target_i        (target_i),
        .result_clk_o    (result_clk_o),
        .result_periods_o(result_periods_o),
        .result_valid_o  (result_valid_o),
        .result_ack_i    (result_ack_i),
        .timeout_o       (timeout_o),
        .overrun_o       (overrun_o),
        .busy_o          (busy_o)
    );

    initial begin
        forever begin
            @(negedge clk_i);
            if (gen_period > 0) begin
                gen_phase = (gen_phase + 1 >= gen_period) ? 0 : gen_phase + 1;
                gen_wave  = (gen_phase < gen_period / 2);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n = 0;
        while (result_valid_o !== 1'b1 && n < bound) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, ".valid"}, 32'(result_valid_o), 32'd1);
    endtask

    task automatic expect_result(input string tag, input int exp_clk, input int exp_per,
                                 input logic exp_to, input int bound);
        wait_valid(tag, bound);
        check({tag, ".clk"}, 32'(result_clk_o), exp_clk);
        check({tag, ".periods"}, 32'(result_periods_o), exp_per);
        check({tag, ".timeout"}, 32'(timeout_o), 32'(exp_to));
        $display("result %s: clk=%0d periods=%0d timeout=%0b overrun=%0b",
                 tag, result_clk_o, result_periods_o, timeout_o, overrun_o);
    endtask

    task automatic do_ack(input string tag);
        result_ack_i = 1'b1;
        @(negedge clk_i);
        result_ack_i = 1'b0;
        check({tag, ".ack_valid"}, 32'(result_valid_o), 32'd0);
        check({tag, ".ack_overrun"}, 32'(overrun_o), 32'd0);
    endtask

    task automatic start_stream(input int p, input int t);
        enable_i = 1'b0;
        @(negedge clk_i);
        gen_level  = 1'b0;
        gen_period = p;
        target_i   = PW'(t);
        repeat (2 * p + 4) @(negedge clk_i);
        enable_i = 1'b1;
    endtask

    task automatic manual_pulses(input int p, input int n);
        gen_period = 0;
        for (int i = 0; i < n; i++) begin
            gen_level = 1'b1;
            repeat (p / 2) @(negedge clk_i);
            gen_level = 1'b0;
            repeat (p - p / 2) @(negedge clk_i);
        end
    endtask

    initial begin
        int k;
        int p;
        int t;

        rst_i        = 1'b0;
        enable_i     = 1'b0;
        result_ack_i = 1'b0;
        target_i     = '0;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst.valid", 32'(result_valid_o), 0);
        check("rst.clk", 32'(result_clk_o), 0);
        check("rst.periods", 32'(result_periods_o), 0);
        check("rst.timeout", 32'(timeout_o), 0);
        check("rst.overrun", 32'(overrun_o), 0);
        check("rst.busy", 32'(busy_o), 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("idle.busy", 32'(busy_o), 0);

        // Target 1, period 10: latency counted in clocks from the negedge that raises fin_i
        enable_i = 1'b1;
        target_i = PW'(1);
        repeat (3) @(negedge clk_i);
        check("arm.busy", 32'(busy_o), 1);
        gen_level = 1'b1;
        k = 0;
        while (k < 40) begin
            @(negedge clk_i);
            k++;
            if (result_valid_o === 1'b1) break;
            if (k == 5 || k == 15) gen_level = 1'b0;
            if (k == 10) gen_level = 1'b1;
        end
        check("lat.cycles", k, SS + 1 + 10);
        expect_result("p10t1", 10, 1, 1'b0, 5);
        do_ack("p10t1");

        // Continuous windows, target change lands two windows later
        start_stream(7, 4);
        expect_result("cont1", 28, 4, 1'b0, 200);
        target_i = PW'(2);
        do_ack("cont1");
        expect_result("cont2", 28, 4, 1'b0, 200);
        do_ack("cont2");
        expect_result("cont3", 14, 2, 1'b0, 200);
        check("cont3.overrun", 32'(overrun_o), 0);
        do_ack("cont3");

        // Target 0 behaves as 1
        start_stream(5, 0);
        expect_result("tgt0", 5, 1, 1'b0, 200);
        do_ack("tgt0");

        // Random period/target pairs kept inside the 8-bit counter range
        for (int i = 0; i < 4; i++) begin
            p = 2 + int'($urandom_range(10, 0));
            t = 1 + int'($urandom_range(240 / p - 1, 0));
            start_stream(p, t);
            expect_result($sformatf("rnd%0d_a", i), p * t, t, 1'b0, 600);
            do_ack($sformatf("rnd%0d_a", i));
            expect_result($sformatf("rnd%0d_b", i), p * t, t, 1'b0, 600);
            do_ack($sformatf("rnd%0d_b", i));
        end

        // Overrun, ack, and ack coincident with a capture (window = 12 cycles)
        start_stream(6, 2);
        wait_valid("ovr_first", 200);
        repeat (12) @(negedge clk_i);
        check("ovr.overrun", 32'(overrun_o), 1);
        check("ovr.valid", 32'(result_valid_o), 1);
        check("ovr.clk", 32'(result_clk_o), 12);
        do_ack("ovr");
        wait_valid("ovr_next", 20);
        repeat (12) @(negedge clk_i);
        check("ovr2.overrun", 32'(overrun_o), 1);
        repeat (11) @(negedge clk_i);
        result_ack_i = 1'b1;
        @(negedge clk_i);
        result_ack_i = 1'b0;
        check("coinc.valid", 32'(result_valid_o), 1);
        check("coinc.overrun", 32'(overrun_o), 0);
        check("coinc.clk", 32'(result_clk_o), 12);
        do_ack("coinc");

        // Timeout: fin_i goes static, counter saturates, block re-arms
        start_stream(6, 1);
        expect_result("pre_tmo", 6, 1, 1'b0, 200);
        do_ack("pre_tmo");
        gen_period = 0;
        gen_level  = 1'b0;
        repeat (10) @(negedge clk_i);
        if (result_valid_o === 1'b1) begin
            result_ack_i = 1'b1;
            @(negedge clk_i);
            result_ack_i = 1'b0;
        end
        expect_result("tmo", SAT, 0, 1'b1, 300);
        check("tmo.busy", 32'(busy_o), 1);
        check("tmo.overrun", 32'(overrun_o), 0);
        do_ack("tmo");
        manual_pulses(9, 2);
        expect_result("post_tmo", 9, 1, 1'b0, 20);
        do_ack("post_tmo");

        // Enable abort mid-window
        start_stream(10, 5);
        expect_result("pre_dis", 50, 5, 1'b0, 300);
        do_ack("pre_dis");
        repeat (20) @(negedge clk_i);
        enable_i = 1'b0;
        @(negedge clk_i);
        check("dis.busy", 32'(busy_o), 0);
        repeat (60) @(negedge clk_i);
        check("dis.valid", 32'(result_valid_o), 0);
        enable_i = 1'b1;
        expect_result("post_dis", 50, 5, 1'b0, 300);

        // Asynchronous reset with a result pending
        repeat (7) @(negedge clk_i);
        #3 rst_i = 1'b0;
        #1;
        check("arst.valid", 32'(result_valid_o), 0);
        check("arst.clk", 32'(result_clk_o), 0);
        check("arst.periods", 32'(result_periods_o), 0);
        check("arst.busy", 32'(busy_o), 0);
        check("arst.overrun", 32'(overrun_o), 0);
        k = 0;
        do begin
            @(negedge clk_i);
            k++;
        end while (fin_i !== 1'b0 && k < 20);
        rst_i = 1'b1;
        expect_result("post_rst", 50, 5, 1'b0, 300);
        do_ack("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
